// File: rtl/debug_uart_tx_pkg.sv
// Shared definitions for the debug UART transmitter: register addresses,
// serializer state encoding and STATUS register bit positions.
package debug_uart_tx_pkg;

  localparam logic [31:0] ADDR_TXDATA = 32'h4000_0004;
  localparam logic [31:0] ADDR_STATUS = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIV    = 32'h4000_0010;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned STATUS_FULL      = 0;
  localparam int unsigned STATUS_EMPTY     = 1;
  localparam int unsigned STATUS_BUSY      = 2;
  localparam int unsigned STATUS_OVERFLOW  = 3;
  localparam int unsigned STATUS_COUNT_LSB = 8;

endpackage

// File: rtl/debug_uart_tx_sync_fifo.sv
// Synchronous FIFO with registered storage.
// Ports: clock, reset (sync, active-high), push/wdata, pop/rdata (rdata valid
// while non-empty), full, empty, count (log2(DEPTH)+1 bits).
// A push while full or a pop while empty is ignored. DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
// Ports: clock, reset (sync, active-high); bus_address/bus_width/bus_wdata/
// bus_read/bus_write from the core; bus_rdata/bus_hit combinational back to the
// fabric; tx serial output (registered, idle high).
// Registers: TXDATA (push byte), STATUS (flags/count, W1C overflow), DIV
// (clock cycles per bit).
module debug_uart_tx
  import debug_uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DEFAULT_DIV = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [1:0]  bus_width,
  input  logic [31:0] bus_wdata,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic [31:0] bus_rdata,
  output logic        bus_hit,
  output logic        tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit_txdata, hit_status, hit_div;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          ovf_set, ovf_clr;
  logic          overflow_q;
  logic [15:0]   div_q;
  logic [31:0]   status;

  tx_state_e     state_q;
  logic [7:0]    shift_q;
  logic [15:0]   cnt_q;
  logic [15:0]   div_lat_q;
  logic [2:0]    idx_q;

  // Loads have no side effects, and the upper store bits are never used.
  logic unused_bus;
  assign unused_bus = ^{bus_read, bus_wdata[31:16]};

  assign hit_txdata = (bus_address == ADDR_TXDATA);
  assign hit_status = (bus_address == ADDR_STATUS);
  assign hit_div    = (bus_address == ADDR_DIV);
  assign bus_hit    = hit_txdata || hit_status || hit_div;

  // Full is judged on the pre-pop count, so a write-while-full is dropped
  // even when the serializer pops in the same cycle.
  assign fifo_push = bus_write && hit_txdata && !fifo_full;
  assign ovf_set   = bus_write && hit_txdata && fifo_full;
  assign ovf_clr   = bus_write && hit_status && bus_wdata[STATUS_OVERFLOW];

  // Pop on leaving IDLE or on the last stop-bit cycle for back-to-back frames.
  assign fifo_pop = !fifo_empty &&
                    ((state_q == StIdle) || ((state_q == StStop) && (cnt_q == '0)));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (bus_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                               = '0;
    status[STATUS_FULL]                  = fifo_full;
    status[STATUS_EMPTY]                 = fifo_empty;
    status[STATUS_BUSY]                  = (state_q != StIdle);
    status[STATUS_OVERFLOW]              = overflow_q;
    status[STATUS_COUNT_LSB +: 8]        = 8'(fifo_count);
  end

  always_comb begin
    bus_rdata = '0;
    if (hit_status)   bus_rdata = status;
    else if (hit_div) bus_rdata = {16'b0, div_q};
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clock) begin
    if (reset)        overflow_q <= 1'b0;
    else if (ovf_set) overflow_q <= 1'b1;
    else if (ovf_clr) overflow_q <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= 16'(DEFAULT_DIV);
    end else if (bus_write && hit_div && (bus_width != 2'd0)) begin
      div_q <= (bus_wdata[15:0] == 16'd0) ? 16'd1 : bus_wdata[15:0];
    end
  end

  // Serializer. cnt_q counts down the cycles left in the current bit;
  // div_lat_q holds the divisor captured when the frame started.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      tx        <= 1'b1;
      shift_q   <= '0;
      cnt_q     <= '0;
      div_lat_q <= 16'(DEFAULT_DIV);
      idx_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx <= 1'b1;
          if (fifo_pop) begin
            shift_q   <= fifo_rdata;
            cnt_q     <= div_q - 16'd1;
            div_lat_q <= div_q;
            tx        <= 1'b0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == '0) begin
            cnt_q   <= div_lat_q - 16'd1;
            idx_q   <= '0;
            tx      <= shift_q[0];
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            cnt_q <= div_lat_q - 16'd1;
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              tx      <= 1'b1;
              state_q <= StStop;
            end else begin
              shift_q <= shift_q >> 1;
              tx      <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StStop: begin
          if (cnt_q == '0) begin
            if (fifo_pop) begin
              shift_q   <= fifo_rdata;
              cnt_q     <= div_q - 16'd1;
              div_lat_q <= div_q;
              tx        <= 1'b0;
              state_q   <= StStart;
            end else begin
              tx      <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Self-checking bench for debug_uart_tx: directed scenarios followed by random
// bus traffic, every cycle compared against a frame-timeline reference model.
module tb_debug_uart_tx;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DEFDIV = 100;
  localparam logic [31:0] A_TX   = 32'h4000_0004;
  localparam logic [31:0] A_STAT = 32'h4000_000C;
  localparam logic [31:0] A_DIV  = 32'h4000_0010;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bus_address;
  logic [1:0]  bus_width;
  logic [31:0] bus_wdata;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_rdata;
  logic        bus_hit;
  logic        tx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  debug_uart_tx #(
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (DEFDIV)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus_address (bus_address),
    .bus_width   (bus_width),
    .bus_wdata   (bus_wdata),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .bus_rdata   (bus_rdata),
    .bus_hit     (bus_hit),
    .tx          (tx)
  );

  // Reference model: pending bytes plus the frame in flight, tracked as the
  // elapsed cycle count within a 10*div frame.
  logic [7:0] m_q[$];
  bit         m_active;
  logic [7:0] m_byte;
  int         m_fdiv;
  int         m_pos;
  int         m_div;
  bit         m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_pos    = 0;
    m_fdiv   = 1;
    m_div    = DEFDIV;
    m_ovf    = 1'b0;
  endfunction

  function automatic logic model_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / m_fdiv;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    return (a == A_TX) || (a == A_STAT) || (a == A_DIV);
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    logic [31:0] r;
    int n;
    r = '0;
    n = m_q.size();
    if (a == A_STAT) begin
      r[0]    = (n == DEPTH);
      r[1]    = (n == 0);
      r[2]    = m_active;
      r[3]    = m_ovf;
      r[15:8] = 8'(n);
    end else if (a == A_DIV) begin
      r = 32'(m_div);
    end
    return r;
  endfunction

  function automatic void model_step(input logic rst, input logic [31:0] a, input logic [1:0] w,
                                     input logic [31:0] d, input logic wr);
    bit last, do_pop, set_ovf;
    int n_pre;
    if (rst) begin
      model_reset();
      return;
    end
    n_pre   = m_q.size();
    last    = m_active && (m_pos == 10 * m_fdiv - 1);
    do_pop  = (n_pre > 0) && (!m_active || last);
    set_ovf = 1'b0;
    if (do_pop) begin
      m_byte   = m_q.pop_front();
      m_fdiv   = m_div;
      m_pos    = 0;
      m_active = 1'b1;
    end else if (m_active) begin
      if (last) m_active = 1'b0;
      else      m_pos++;
    end
    if (wr && a == A_TX) begin
      if (n_pre == DEPTH) set_ovf = 1'b1;
      else                m_q.push_back(d[7:0]);
    end
    if (wr && a == A_STAT && d[3]) m_ovf = 1'b0;
    if (set_ovf) m_ovf = 1'b1;
    if (wr && a == A_DIV && w != 2'd0) m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
  endfunction

  // One bus cycle: drive, check outputs at the falling edge, advance the model.
  task automatic step(input logic rst, input logic [31:0] a, input logic [1:0] w,
                      input logic [31:0] d, input logic rd, input logic wr,
                      input bit use_const, input logic [31:0] const_exp);
    reset       = rst;
    bus_address = a;
    bus_width   = w;
    bus_wdata   = d;
    bus_read    = rd;
    bus_write   = wr;
    @(negedge clock);
    check_eq("tx", {31'b0, tx}, {31'b0, model_tx()});
    if (rd) begin
      check_eq("hit", {31'b0, bus_hit}, {31'b0, model_hit(a)});
      check_eq("rdata", bus_rdata, model_rdata(a));
      if (use_const) check_eq("rdata_const", bus_rdata, const_exp);
    end
    @(posedge clock);
    model_step(rst, a, w, d, wr);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    step(1'b0, a, w, d, 1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic bus_rd(input logic [31:0] a);
    step(1'b0, a, 2'd2, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic bus_rd_exp(input logic [31:0] a, input logic [31:0] exp);
    step(1'b0, a, 2'd2, 32'h0, 1'b1, 1'b0, 1'b1, exp);
  endtask

  initial begin
    logic [31:0] addrs [6];
    int r;
    addrs[0] = A_TX;  addrs[1] = A_STAT;       addrs[2] = A_DIV;
    addrs[3] = 32'h4000_0008; addrs[4] = 32'h4000_0000; addrs[5] = 32'h0;

    model_reset();
    reset = 1'b1; bus_address = '0; bus_width = '0; bus_wdata = '0;
    bus_read = 1'b0; bus_write = 1'b0;
    do_reset();
    do_reset();
    bus_rd_exp(A_STAT, 32'h0000_0002);
    bus_rd_exp(A_DIV, 32'd100);

    // Single frame at DIV=4, then idle.
    bus_wr(A_DIV, 2'd2, 32'd4);
    bus_wr(A_TX, 2'd0, 32'h55);
    idle(42);
    bus_rd_exp(A_STAT, 32'h0000_0002);
    bus_rd_exp(A_TX, 32'h0);

    // Back-to-back frames at DIV=2.
    bus_wr(A_DIV, 2'd1, 32'd2);
    bus_wr(A_TX, 2'd0, 32'h41);
    bus_wr(A_TX, 2'd0, 32'h42);
    idle(45);

    // Fill to full and overflow at DIV=1000, then clear overflow.
    bus_wr(A_DIV, 2'd2, 32'd1000);
    for (int i = 0; i < 17; i++) bus_wr(A_TX, 2'd0, 32'(8'h30 + i));
    bus_rd_exp(A_STAT, 32'h0000_1005);
    bus_wr(A_TX, 2'd0, 32'hEE);
    bus_rd_exp(A_STAT, 32'h0000_100D);
    bus_wr(A_STAT, 2'd2, 32'h8);
    bus_rd_exp(A_STAT, 32'h0000_1005);
    do_reset();

    // DIV=0 stored as 1; byte stores to DIV ignored.
    bus_wr(A_DIV, 2'd2, 32'h0);
    bus_rd_exp(A_DIV, 32'd1);
    bus_wr(A_TX, 2'd0, 32'hC3);
    idle(12);
    bus_wr(A_DIV, 2'd0, 32'hFF);
    bus_rd_exp(A_DIV, 32'd1);

    // Divisor change mid-frame only affects the next frame.
    bus_wr(A_DIV, 2'd2, 32'd4);
    bus_wr(A_TX, 2'd0, 32'h3C);
    idle(10);
    bus_wr(A_DIV, 2'd1, 32'd8);
    bus_wr(A_TX, 2'd0, 32'h96);
    idle(115);

    // Reset during a data bit.
    bus_wr(A_DIV, 2'd2, 32'd4);
    bus_wr(A_TX, 2'd0, 32'hA5);
    bus_wr(A_TX, 2'd0, 32'h5A);
    idle(14);
    do_reset();
    bus_rd_exp(A_STAT, 32'h0000_0002);
    bus_rd_exp(32'h4000_0008, 32'h0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(99));
      if (r < 2) begin
        do_reset();
      end else if (r < 30) begin
        bus_wr(A_TX, 2'($urandom_range(2)), $urandom);
      end else if (r < 34) begin
        bus_wr(A_DIV, 2'($urandom_range(2)), 32'($urandom_range(6)));
      end else if (r < 38) begin
        bus_wr(A_STAT, 2'd2, {28'($urandom), 1'($urandom), 3'($urandom)});
      end else if (r < 60) begin
        if ($urandom_range(9) == 0) bus_rd($urandom);
        else bus_rd(addrs[$urandom_range(5)]);
      end else begin
        idle(1);
      end
    end
    idle(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
